shot_resolver: RTL

Consumer side of the ship-placement path: takes a completed 5x5 board snapshot (as produced by the placement state), counts its ship cells, then resolves fire requests one at a time. Each shot returns a hit, miss, repeat or invalid result, marks the board, and tracks remaining ship cells. It drives the opponent-board view for the VGA path and the game-over flag for the top-level game FSM.

---
 rtl/shot_resolver.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/shot_resolver.sv
// Takes a 5x5 board snapshot, counts its ship cells in 25 cycles, then resolves one shot per 3 cycles.
// A shot's result arrives 2 cycles after fire; fire is dropped while busy, and load preempts any activity.
module shot_resolver #(
  parameter int BOARD_N = 5
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 load,
  input  logic [BOARD_N-1:0][BOARD_N-1:0][1:0] board_in,
  input  logic                                 fire,
  input  logic [2:0]                           i_shot,
  input  logic [2:0]                           j_shot,
  output logic                                 busy,
  output logic                                 result_valid,
  output logic [1:0]                           result,
  output logic [4:0]                           remaining,
  output logic                                 all_sunk,
  output logic [5:0]                           shots_fired,
  output logic [BOARD_N-1:0][BOARD_N-1:0][1:0] board_out
);

  typedef enum logic [1:0] {IDLE, COUNT, CHECK, RESP} state_t;

  localparam logic [2:0] LAST      = 3'(BOARD_N - 1);
  localparam logic [1:0] CELL_AGUA = 2'b00;
  localparam logic [1:0] CELL_SHIP = 2'b01;
  localparam logic [1:0] CELL_MISS = 2'b10;
  localparam logic [1:0] CELL_HIT  = 2'b11;
  localparam logic [1:0] RES_MISS  = 2'b00;
  localparam logic [1:0] RES_HIT   = 2'b01;
  localparam logic [1:0] RES_REP   = 2'b10;
  localparam logic [1:0] RES_INV   = 2'b11;

  state_t state_q, state_d;
  logic [BOARD_N-1:0][BOARD_N-1:0][1:0] board_q, board_d;
  logic [4:0] remaining_q, remaining_d;
  logic [5:0] shots_q, shots_d;
  logic [2:0] scan_r_q, scan_r_d, scan_c_q, scan_c_d;
  logic [2:0] shot_i_q, shot_i_d, shot_j_q, shot_j_d;
  logic [1:0] result_q, result_d;
  logic       loaded_q, loaded_d;
  logic       all_sunk_q, all_sunk_d;
  logic       fire_ok;
  logic       scan_last;

  assign fire_ok   = fire && loaded_q && !all_sunk_q;
  assign scan_last = (scan_r_q == LAST) && (scan_c_q == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = COUNT;
    end else begin
      case (state_q)
        IDLE:    if (fire_ok) state_d = CHECK;
        COUNT:   if (scan_last) state_d = IDLE;
        CHECK:   state_d = RESP;
        RESP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy         = (state_q != IDLE);
    result_valid = (state_q == RESP);
  end

  always_comb begin
    board_d     = board_q;
    remaining_d = remaining_q;
    shots_d     = shots_q;
    scan_r_d    = scan_r_q;
    scan_c_d    = scan_c_q;
    shot_i_d    = shot_i_q;
    shot_j_d    = shot_j_q;
    result_d    = result_q;
    loaded_d    = loaded_q;
    all_sunk_d  = all_sunk_q;
    if (load) begin
      board_d     = board_in;
      remaining_d = '0;
      shots_d     = '0;
      scan_r_d    = '0;
      scan_c_d    = '0;
      loaded_d    = 1'b1;
      all_sunk_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fire_ok) begin
            shot_i_d = i_shot;
            shot_j_d = j_shot;
          end
        end
        COUNT: begin
          if (board_q[scan_r_q][scan_c_q] == CELL_SHIP) remaining_d = remaining_q + 5'd1;
          if (scan_c_q == LAST) begin
            scan_c_d = '0;
            scan_r_d = scan_r_q + 3'd1;
          end else begin
            scan_c_d = scan_c_q + 3'd1;
          end
          if (scan_last) all_sunk_d = (remaining_d == '0);
        end
        CHECK: begin
          // Guard the index: out-of-range coordinates must never touch the board.
          if ((shot_i_q > LAST) || (shot_j_q > LAST)) begin
            result_d = RES_INV;
          end else begin
            case (board_q[shot_i_q][shot_j_q])
              CELL_AGUA: begin
                board_d[shot_i_q][shot_j_q] = CELL_MISS;
                result_d = RES_MISS;
                if (shots_q != 6'd63) shots_d = shots_q + 6'd1;
              end
              CELL_SHIP: begin
                board_d[shot_i_q][shot_j_q] = CELL_HIT;
                result_d    = RES_HIT;
                remaining_d = remaining_q - 5'd1;
                all_sunk_d  = (remaining_q == 5'd1);
                if (shots_q != 6'd63) shots_d = shots_q + 6'd1;
              end
              default: result_d = RES_REP;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      board_q     <= '0;
      remaining_q <= '0;
      shots_q     <= '0;
      scan_r_q    <= '0;
      scan_c_q    <= '0;
      shot_i_q    <= '0;
      shot_j_q    <= '0;
      result_q    <= '0;
      loaded_q    <= 1'b0;
      all_sunk_q  <= 1'b0;
    end else begin
      board_q     <= board_d;
      remaining_q <= remaining_d;
      shots_q     <= shots_d;
      scan_r_q    <= scan_r_d;
      scan_c_q    <= scan_c_d;
      shot_i_q    <= shot_i_d;
      shot_j_q    <= shot_j_d;
      result_q    <= result_d;
      loaded_q    <= loaded_d;
      all_sunk_q  <= all_sunk_d;
    end
  end

  assign result      = result_q;
  assign remaining   = remaining_q;
  assign all_sunk    = all_sunk_q;
  assign shots_fired = shots_q;
  assign board_out   = board_q;

endmodule
